// File: rtl/usb_ep_buffer.sv
// Per-endpoint circular byte FIFOs shared by a byte-wide USB port and a 1/2/4-byte AHB port.
// Pops register data one cycle after the strobe; optional sticky error flags via USB_EP_BUFFER_ERR_EN.
module usb_ep_buffer #(
   parameter int NUM_EP = 2,
   parameter int DEPTH  = 64
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [NUM_EP-1:0]                        clear,
   input  logic [((NUM_EP > 1) ? $clog2(NUM_EP) : 1)-1:0] usb_ep,
   input  logic                                     store_rx_packet_data,
   input  logic [7:0]                               rx_packet_data,
   input  logic                                     get_tx_packet_data,
   output logic [7:0]                               tx_packet_data,
   input  logic [((NUM_EP > 1) ? $clog2(NUM_EP) : 1)-1:0] ahb_ep,
   input  logic [1:0]                               data_size,
   input  logic                                     store_tx_data,
   input  logic [31:0]                              tx_data,
   input  logic                                     get_rx_data,
   output logic [31:0]                              rx_data,
   output logic [NUM_EP*($clog2(DEPTH)+1)-1:0]      buffer_occupancy,
   output logic [NUM_EP-1:0]                        err
);

   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = AW + 1;
   localparam int EPW = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;

   logic [7:0]    r_mem  [NUM_EP][DEPTH];
   logic [AW-1:0] r_rptr [NUM_EP];
   logic [AW-1:0] r_wptr [NUM_EP];
   logic [CW-1:0] r_cnt  [NUM_EP];
   logic [7:0]    r_tx;
   logic [31:0]   r_rx;

   logic [2:0]        w_ahb_n;
   logic [NUM_EP-1:0] w_usb_push;
   logic [NUM_EP-1:0] w_ahb_push;
   logic [NUM_EP-1:0] w_usb_pop;
   logic [NUM_EP-1:0] w_ahb_pop;
   logic [NUM_EP-1:0] w_unf;
   logic [NUM_EP-1:0] w_drop;
   logic [2:0]        w_pop_req  [NUM_EP];
   logic [2:0]        w_pop_n    [NUM_EP];
   logic [2:0]        w_push_req [NUM_EP];
   logic [2:0]        w_push_n   [NUM_EP];
   logic [CW-1:0]     w_cnt_mid  [NUM_EP];
   logic              w_we [NUM_EP][4];
   logic [AW-1:0]     w_wa [NUM_EP][4];
   logic [7:0]        w_wd [NUM_EP][4];
   logic              w_tx_upd;
   logic [7:0]        w_tx_byte;
   logic              w_rx_upd;
   logic [31:0]       w_rx_word;

   always_comb begin
      case (data_size)
         2'd0:    w_ahb_n = 3'd1;
         2'd1:    w_ahb_n = 3'd2;
         default: w_ahb_n = 3'd4;
      endcase
   end

   // Pops are resolved before pushes so a same-cycle pop frees space for the push.
   always_comb begin
      for (int i = 0; i < NUM_EP; i++) begin
         w_usb_push[i] = store_rx_packet_data && (usb_ep == EPW'(i)) && !clear[i];
         w_ahb_push[i] = store_tx_data && (ahb_ep == EPW'(i)) && !clear[i];
         w_usb_pop[i]  = get_tx_packet_data && (usb_ep == EPW'(i)) && !clear[i];
         w_ahb_pop[i]  = get_rx_data && (ahb_ep == EPW'(i)) && !clear[i] && !w_usb_pop[i];

         w_pop_req[i] = w_usb_pop[i] ? 3'd1 : (w_ahb_pop[i] ? w_ahb_n : 3'd0);
         w_unf[i]     = CW'(w_pop_req[i]) > r_cnt[i];
         w_pop_n[i]   = w_unf[i] ? r_cnt[i][2:0] : w_pop_req[i];
         w_cnt_mid[i] = r_cnt[i] - CW'(w_pop_n[i]);

         w_push_req[i] = w_usb_push[i] ? 3'd1 : (w_ahb_push[i] ? w_ahb_n : 3'd0);
         w_drop[i]     = CW'(w_push_req[i]) > (CW'(DEPTH) - w_cnt_mid[i]);
         w_push_n[i]   = w_drop[i] ? 3'd0 : w_push_req[i];

         for (int k = 0; k < 4; k++) begin
            w_we[i][k] = 3'(k) < w_push_n[i];
            w_wa[i][k] = r_wptr[i] + AW'(k);
            w_wd[i][k] = w_usb_push[i] ? rx_packet_data : tx_data[8*k +: 8];
         end
      end
   end

   always_comb begin
      w_tx_upd  = 1'b0;
      w_tx_byte = 8'h00;
      w_rx_upd  = 1'b0;
      w_rx_word = 32'h0;
      for (int i = 0; i < NUM_EP; i++) begin
         if (w_usb_pop[i]) begin
            w_tx_upd  = 1'b1;
            w_tx_byte = (w_pop_n[i] != 3'd0) ? r_mem[i][r_rptr[i]] : 8'h00;
         end
         if (w_ahb_pop[i]) begin
            w_rx_upd = 1'b1;
            for (int k = 0; k < 4; k++) begin
               if (3'(k) < w_pop_n[i]) begin
                  w_rx_word[8*k +: 8] = r_mem[i][r_rptr[i] + AW'(k)];
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_EP; i++) begin
         for (int k = 0; k < 4; k++) begin
            if (w_we[i][k]) begin
               r_mem[i][w_wa[i][k]] <= w_wd[i][k];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_EP; i++) begin
         if (rst || clear[i]) begin
            r_rptr[i] <= '0;
            r_wptr[i] <= '0;
            r_cnt[i]  <= '0;
         end else begin
            r_rptr[i] <= r_rptr[i] + AW'(w_pop_n[i]);
            r_wptr[i] <= r_wptr[i] + AW'(w_push_n[i]);
            r_cnt[i]  <= w_cnt_mid[i] + CW'(w_push_n[i]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx <= 8'h00;
         r_rx <= 32'h0;
      end else begin
         if (w_tx_upd) r_tx <= w_tx_byte;
         if (w_rx_upd) r_rx <= w_rx_word;
      end
   end

   assign tx_packet_data = r_tx;
   assign rx_data        = r_rx;

   always_comb begin
      buffer_occupancy = '0;
      for (int i = 0; i < NUM_EP; i++) begin
         buffer_occupancy[i*CW +: CW] = r_cnt[i];
      end
   end

`ifdef USB_EP_BUFFER_ERR_EN
   logic [NUM_EP-1:0] r_err;

   // A USB/AHB push collision counts as an AHB overflow even when the USB byte fits.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_EP; i++) begin
         if (rst || clear[i]) begin
            r_err[i] <= 1'b0;
         end else if (w_drop[i] || w_unf[i] || (w_usb_push[i] && w_ahb_push[i])) begin
            r_err[i] <= 1'b1;
         end
      end
   end

   assign err = r_err;
`else
   assign err = '0;
`endif

endmodule

// File: tb/tb_usb_ep_buffer.sv
// Bench for usb_ep_buffer: queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_usb_ep_buffer;

   localparam int NUM_EP = 2;
   localparam int DEPTH  = 64;
   localparam int CW     = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              rst;
   logic [NUM_EP-1:0] clear;
   logic              usb_ep;
   logic              store_rx_packet_data;
   logic [7:0]        rx_packet_data;
   logic              get_tx_packet_data;
   logic [7:0]        tx_packet_data;
   logic              ahb_ep;
   logic [1:0]        data_size;
   logic              store_tx_data;
   logic [31:0]       tx_data;
   logic              get_rx_data;
   logic [31:0]       rx_data;
   logic [NUM_EP*CW-1:0] buffer_occupancy;
   logic [NUM_EP-1:0] err;

   usb_ep_buffer #(.NUM_EP(NUM_EP), .DEPTH(DEPTH)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .clear                (clear),
      .usb_ep               (usb_ep),
      .store_rx_packet_data (store_rx_packet_data),
      .rx_packet_data       (rx_packet_data),
      .get_tx_packet_data   (get_tx_packet_data),
      .tx_packet_data       (tx_packet_data),
      .ahb_ep               (ahb_ep),
      .data_size            (data_size),
      .store_tx_data        (store_tx_data),
      .tx_data              (tx_data),
      .get_rx_data          (get_rx_data),
      .rx_data              (rx_data),
      .buffer_occupancy     (buffer_occupancy),
      .err                  (err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   logic chk_en = 1'b0;

   logic [7:0]        mq [NUM_EP][$];
   logic [7:0]        m_tx;
   logic [31:0]       m_rx;
   logic [NUM_EP-1:0] m_err;

   function automatic logic [NUM_EP-1:0] exp_err();
`ifdef USB_EP_BUFFER_ERR_EN
      return m_err;
`else
      return '0;
`endif
   endfunction

   function automatic int occ(input int i);
      return int'(buffer_occupancy[i*CW +: CW]);
   endfunction

   // Reference: each endpoint is just a byte queue; pops happen before pushes within a cycle.
   task automatic model_step();
      int n;
      logic [31:0] w;
      logic up, ap, uo, ao;
      n = (data_size == 2'd0) ? 1 : ((data_size == 2'd1) ? 2 : 4);
      if (rst) begin
         for (int i = 0; i < NUM_EP; i++) mq[i].delete();
         m_err = '0;
         m_tx  = 8'h00;
         m_rx  = 32'h0;
         return;
      end
      for (int i = 0; i < NUM_EP; i++) begin
         if (clear[i]) begin
            mq[i].delete();
            m_err[i] = 1'b0;
            continue;
         end
         up = store_rx_packet_data && (int'(usb_ep) == i);
         ap = store_tx_data && (int'(ahb_ep) == i);
         uo = get_tx_packet_data && (int'(usb_ep) == i);
         ao = get_rx_data && (int'(ahb_ep) == i) && !uo;
         if (uo) begin
            if (mq[i].size() > 0) m_tx = mq[i].pop_front();
            else begin
               m_tx = 8'h00;
               m_err[i] = 1'b1;
            end
         end
         if (ao) begin
            w = 32'h0;
            for (int k = 0; k < n; k++) begin
               if (mq[i].size() > 0) w[8*k +: 8] = mq[i].pop_front();
               else m_err[i] = 1'b1;
            end
            m_rx = w;
         end
         if (up && ap) m_err[i] = 1'b1;
         if (up) begin
            if (mq[i].size() < DEPTH) mq[i].push_back(rx_packet_data);
            else m_err[i] = 1'b1;
         end else if (ap) begin
            if (mq[i].size() + n <= DEPTH) begin
               for (int k = 0; k < n; k++) mq[i].push_back(tx_data[8*k +: 8]);
            end else m_err[i] = 1'b1;
         end
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         n_cmp++;
         if (tx_packet_data !== m_tx) begin
            n_bad++;
            $display("FAIL tx_packet_data @%0t: got %02h want %02h", $time, tx_packet_data, m_tx);
         end
         n_cmp++;
         if (rx_data !== m_rx) begin
            n_bad++;
            $display("FAIL rx_data @%0t: got %08h want %08h", $time, rx_data, m_rx);
         end
         for (int i = 0; i < NUM_EP; i++) begin
            n_cmp++;
            if (occ(i) != mq[i].size()) begin
               n_bad++;
               $display("FAIL occupancy ep%0d @%0t: got %0d want %0d", i, $time, occ(i), mq[i].size());
            end
         end
         n_cmp++;
         if (err !== exp_err()) begin
            n_bad++;
            $display("FAIL err @%0t: got %b want %b", $time, err, exp_err());
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %08h want %08h", nm, act, want);
      end
   endtask

   task automatic idle();
      rst = 1'b0;
      clear = '0;
      store_rx_packet_data = 1'b0;
      get_tx_packet_data = 1'b0;
      store_tx_data = 1'b0;
      get_rx_data = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      idle();
   endtask

   task automatic usb_push(input logic ep, input logic [7:0] b);
      usb_ep = ep; store_rx_packet_data = 1'b1; rx_packet_data = b;
   endtask

   task automatic usb_pop(input logic ep);
      usb_ep = ep; get_tx_packet_data = 1'b1;
   endtask

   task automatic ahb_push(input logic ep, input logic [1:0] sz, input logic [31:0] d);
      ahb_ep = ep; data_size = sz; store_tx_data = 1'b1; tx_data = d;
   endtask

   task automatic ahb_pop(input logic ep, input logic [1:0] sz);
      ahb_ep = ep; data_size = sz; get_rx_data = 1'b1;
   endtask

   task automatic chk_err(input string nm, input int ep, input logic want_when_en);
`ifdef USB_EP_BUFFER_ERR_EN
      chk(nm, 32'(err[ep]), 32'(want_when_en));
`else
      chk(nm, 32'(err[ep]), 32'h0);
`endif
   endtask

   logic [7:0] exp_bytes [4];

   initial begin
      idle();
      usb_ep = 1'b0; ahb_ep = 1'b0; data_size = 2'd0;
      rx_packet_data = 8'h00; tx_data = 32'h0;
      m_err = '0; m_tx = 8'h00; m_rx = 32'h0;

      rst = 1'b1; tick();
      chk_en = 1'b1;
      rst = 1'b1; tick();
      chk("reset tx", 32'(tx_packet_data), 32'h0);
      chk("reset rx", rx_data, 32'h0);
      chk("reset occ", 32'(buffer_occupancy), 32'h0);
      chk("reset err", 32'(err), 32'h0);

      // AHB word in, four USB bytes out
      ahb_push(1'b0, 2'd2, 32'hDDCCBBAA); tick();
      chk("ahb push occ0", 32'(occ(0)), 32'd4);
      exp_bytes[0] = 8'hAA; exp_bytes[1] = 8'hBB; exp_bytes[2] = 8'hCC; exp_bytes[3] = 8'hDD;
      for (int k = 0; k < 4; k++) begin
         usb_pop(1'b0); tick();
         chk("usb pop byte", 32'(tx_packet_data), 32'(exp_bytes[k]));
      end
      chk("usb pop occ0 empty", 32'(occ(0)), 32'd0);

      // Fill EP1, overflow, then AHB word pop
      for (int k = 0; k < 64; k++) begin
         usb_push(1'b1, 8'(k)); tick();
      end
      chk("ep1 full occ", 32'(occ(1)), 32'd64);
      usb_push(1'b1, 8'h40); tick();
      chk("ep1 overflow occ", 32'(occ(1)), 32'd64);
      chk_err("ep1 overflow err", 1, 1'b1);
      ahb_pop(1'b1, 2'd2); tick();
      chk("ep1 ahb pop data", rx_data, 32'h03020100);
      chk("ep1 ahb pop occ", 32'(occ(1)), 32'd60);
      clear[1] = 1'b1; tick();
      chk("ep1 clear occ", 32'(occ(1)), 32'd0);
      chk_err("ep1 clear err", 1, 1'b0);

      // Pointer wrap on EP0
      clear[0] = 1'b1; tick();
      for (int k = 0; k < 62; k++) begin
         usb_push(1'b0, 8'($urandom)); tick();
      end
      chk("ep0 fill 62", 32'(occ(0)), 32'd62);
      for (int k = 0; k < 62; k++) begin
         usb_pop(1'b0); tick();
      end
      ahb_push(1'b0, 2'd2, 32'h11223344); tick();
      ahb_pop(1'b0, 2'd2); tick();
      chk("wrap pop data", rx_data, 32'h11223344);

      // Underflow: two bytes available, four requested
      usb_push(1'b0, 8'h55); tick();
      usb_push(1'b0, 8'h66); tick();
      ahb_pop(1'b0, 2'd2); tick();
      chk("underflow data", rx_data, 32'h00006655);
      chk("underflow occ", 32'(occ(0)), 32'd0);
      chk_err("underflow err", 0, 1'b1);
      clear[0] = 1'b1; tick();
      chk_err("clear err0", 0, 1'b0);

      // USB/AHB push collision on EP1, with an independent EP0 push
      usb_push(1'b1, 8'h77); ahb_push(1'b1, 2'd2, 32'hA1B2C3D4); tick();
      chk("collision occ1", 32'(occ(1)), 32'd1);
      chk_err("collision err1", 1, 1'b1);
      usb_push(1'b1, 8'h78); ahb_push(1'b0, 2'd2, 32'hCAFEF00D); tick();
      chk("independent occ0", 32'(occ(0)), 32'd4);
      chk("independent occ1", 32'(occ(1)), 32'd2);
      usb_pop(1'b1); ahb_pop(1'b0, 2'd2); tick();
      chk("collision stored byte", 32'(tx_packet_data), 32'h77);
      chk("independent ep0 word", rx_data, 32'hCAFEF00D);

      // Same-endpoint pop collision: USB wins, rx_data held
      usb_pop(1'b1); ahb_pop(1'b1, 2'd0); tick();
      chk("pop collision tx", 32'(tx_packet_data), 32'h78);
      chk("pop collision rx held", rx_data, 32'hCAFEF00D);

      // Reset with data stored and strobes active
      ahb_push(1'b0, 2'd2, 32'h01020304); tick();
      usb_push(1'b1, 8'h99); tick();
      rst = 1'b1; usb_push(1'b1, 8'h5A); ahb_push(1'b0, 2'd1, 32'h1234); tick();
      chk("rst occ", 32'(buffer_occupancy), 32'h0);
      chk("rst err", 32'(err), 32'h0);
      chk("rst tx", 32'(tx_packet_data), 32'h0);
      chk("rst rx", rx_data, 32'h0);

      for (int c = 0; c < 4000; c++) begin
         rst = ($urandom_range(0, 499) == 0);
         clear[0] = ($urandom_range(0, 59) == 0);
         clear[1] = ($urandom_range(0, 59) == 0);
         usb_ep = 1'($urandom_range(0, 1));
         ahb_ep = 1'($urandom_range(0, 1));
         data_size = 2'($urandom_range(0, 3));
         store_rx_packet_data = ($urandom_range(0, 2) == 0);
         rx_packet_data = 8'($urandom);
         get_tx_packet_data = ($urandom_range(0, 2) == 0);
         store_tx_data = ($urandom_range(0, 2) == 0);
         tx_data = $urandom;
         get_rx_data = ($urandom_range(0, 3) == 0);
         tick();
      end

      @(negedge clk);
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/usb_ep_buffer.md
USB_EP_BUFFER -- requirements
Module: usb_ep_buffer

Interface
REQ-001 SHALL have parameter NUM_EP, default 2, number of independent endpoint byte FIFOs (1..8).
REQ-002 SHALL have parameter DEPTH, default 64, bytes per endpoint FIFO (power of two, 8..256); AW = log2(DEPTH).
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous active-high reset
- clear  in  NUM_EP  per-endpoint flush
- usb_ep  in  log2(NUM_EP) (min 1)  endpoint addressed by USB-side strobes
- store_rx_packet_data  in  1  push rx_packet_data into FIFO[usb_ep]
- rx_packet_data  in  8  received byte
- get_tx_packet_data  in  1  pop one byte from FIFO[usb_ep]
- tx_packet_data  out  8  popped byte
- ahb_ep  in  log2(NUM_EP) (min 1)  endpoint addressed by AHB-side strobes
- data_size  in  2  AHB transfer size: 0=1B, 1=2B, 2=4B, 3=4B
- store_tx_data  in  1  push data_size bytes of tx_data into FIFO[ahb_ep]
- tx_data  in  32  write word, byte 0 in bits 7:0
- get_rx_data  in  1  pop data_size bytes from FIFO[ahb_ep]
- rx_data  out  32  popped word, byte 0 in bits 7:0, unused upper bytes 0
- buffer_occupancy  out  NUM_EP*(AW+1)  byte count per endpoint, EP i at bits [i*(AW+1) +: AW+1]
- err  out  NUM_EP  sticky per-endpoint overflow/underflow flag

Function
REQ-004 Each FIFO SHALL be circular: read pointer, write pointer and count (0..DEPTH), pointers wrap modulo DEPTH.
REQ-005 USB push SHALL write 1 byte at wptr; wptr+1, count+1.
REQ-006 AHB push SHALL write N bytes (N per data_size) at wptr..wptr+N-1 (wrapping), byte 0 first; wptr+N, count+N.
REQ-007 USB pop SHALL register the byte at rptr onto tx_packet_data one cycle after the strobe; rptr+1, count-1.
REQ-008 AHB pop SHALL register bytes rptr..rptr+N-1 onto rx_data one cycle after the strobe; rptr+N, count-N.
REQ-009 tx_packet_data and rx_data SHALL hold their last value when no pop occurs.
REQ-010 Overflow (push of N > DEPTH-count) SHALL drop the entire push; FIFO unchanged.
REQ-011 Underflow (pop of N > count) SHALL return the count available bytes in low lanes, zeros above, and leave the FIFO empty (rptr=wptr, count=0).
REQ-012 Push and pop on the same endpoint in one cycle SHALL both take effect; count = count + pushed - popped; an overflow check SHALL use count after the same-cycle pop.
REQ-013 USB push and AHB push to the same endpoint in one cycle: USB push SHALL win, AHB push dropped and treated as overflow.
REQ-014 USB pop and AHB pop to the same endpoint in one cycle: USB pop SHALL win, AHB pop ignored, rx_data held.
REQ-015 clear[i] SHALL zero pointers and count of FIFO i next cycle, overriding any same-cycle push/pop to FIFO i, and SHALL clear err[i].
REQ-016 Operations on different endpoints in the same cycle SHALL be independent.
REQ-017 buffer_occupancy SHALL reflect registered counts (updated the cycle after the operation).

Reset
REQ-018 rst SHALL set all pointers, counts, buffer_occupancy, err, rx_data and tx_packet_data to 0 on the next clk edge, overriding all strobes and clear; FIFO storage contents need not be reset.
REQ-019 Reset asserted mid-transfer SHALL discard all stored bytes.

Configuration
REQ-020 With USB_EP_BUFFER_ERR_EN defined, err[i] SHALL set on any overflow (REQ-010, REQ-013) or underflow (REQ-011) on FIFO i and hold until clear[i] or rst.
REQ-021 Without USB_EP_BUFFER_ERR_EN, err SHALL be constant 0 and no error state SHALL be synthesised; drop/underflow data behaviour unchanged.

Verification (NUM_EP=2, DEPTH=64, ERR_EN defined)
REQ-022 AHB push 0xDDCCBBAA size=2 to EP0, then 4 USB pops EP0 -> tx_packet_data AA,BB,CC,DD one cycle after each strobe; occupancy EP0 4->0.
REQ-023 64 USB pushes 0x00..0x3F to EP1, then AHB pop size=2 -> rx_data 0x03020100, occupancy 60; a 65th push before the pop -> dropped, err[1]=1.
REQ-024 Fill EP0 to 62, pop 62, push 0x11223344 size=2 (wraps at 63->0), AHB pop size=2 -> rx_data 0x11223344.
REQ-025 EP0 holds 2 bytes 0x55,0x66; AHB pop size=2 -> rx_data 0x00006655, occupancy 0, err[0]=1; clear[0] -> err[0]=0.
REQ-026 Same-cycle USB push 0x77 and AHB push to EP1 -> only 0x77 stored, occupancy +1, err[1]=1; EP0 same-cycle AHB push unaffected.
REQ-027 rst asserted with both FIFOs non-empty and strobes active -> all occupancy, err, rx_data, tx_packet_data 0 next cycle.
